// File: rtl/input_port_buffer_pkg.sv
// Shared types for the router input port: flit layout, output port encoding,
// buffer FSM states and the XY routing rule.
package input_port_buffer_pkg;

  localparam int DEF_MESH_SIZE_X = 4;
  localparam int DEF_MESH_SIZE_Y = 4;
  localparam int X_DES_W         = $clog2(DEF_MESH_SIZE_X);
  localparam int Y_DES_W         = $clog2(DEF_MESH_SIZE_Y);
  localparam int PAYLOAD_W       = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_Data_Label;

  typedef struct packed {
    logic [X_DES_W-1:0] x_Dest;
    logic [Y_DES_W-1:0] y_Dest;
  } packet_Head;

  typedef struct packed {
    flit_Data_Label        label;
    packet_Head            head;
    logic [PAYLOAD_W-1:0]  payload;
  } flit_Data;

  localparam int FLIT_W = $bits(flit_Data);

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } port_Dir;

  typedef enum logic {
    IDLE   = 1'b0,
    ROUTED = 1'b1
  } buf_state_e;

  function automatic logic is_head(flit_Data_Label l);
    return (l == HEAD) || (l == HEADTAIL);
  endfunction

  // Dimension-ordered routing: resolve X completely before moving in Y.
  function automatic port_Dir xy_route(packet_Head h,
                                       logic [X_DES_W-1:0] cur_x,
                                       logic [Y_DES_W-1:0] cur_y);
    if (h.x_Dest > cur_x)      return EAST;
    else if (h.x_Dest < cur_x) return WEST;
    else if (h.y_Dest > cur_y) return NORTH;
    else if (h.y_Dest < cur_y) return SOUTH;
    else                       return LOCAL;
  endfunction

endpackage

// File: rtl/input_port_buffer_if.sv
// Upstream and allocator-side handshake of one router input port.
interface input_port_buffer_if;

  logic                                valid_In;
  input_port_buffer_pkg::flit_Data     flit_In;
  logic                                ready_Out;
  logic                                valid_Out;
  input_port_buffer_pkg::flit_Data     flit_Out;
  input_port_buffer_pkg::port_Dir      route_Out;
  logic                                ready_In;
  logic                                error_Out;

  modport slave (
    input  valid_In, flit_In, ready_In,
    output ready_Out, valid_Out, flit_Out, route_Out, error_Out
  );

  modport master (
    output valid_In, flit_In, ready_In,
    input  ready_Out, valid_Out, flit_Out, route_Out, error_Out
  );

endinterface

// File: rtl/input_port_buffer_flit_fifo.sv
// Power-of-two flit FIFO with naturally wrapping pointers and a registered
// full flag, so the upstream ready never depends on this cycle's pop.
module flit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q;

  // NOTE: every variable gets a value before any branch, otherwise a latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage is reset too, so flit_Out reads all-zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (push_i) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL_COUNT);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = full_q;

endmodule

// File: rtl/input_port_buffer.sv
// Router input stage: buffers flits, computes the XY output port from each
// head flit and holds it for the remainder of the packet.
module input_port_buffer
  import input_port_buffer_pkg::*;
#(
  parameter int BUFFER_DEPTH = 4,
  parameter int MESH_SIZE_X  = DEF_MESH_SIZE_X,
  parameter int MESH_SIZE_Y  = DEF_MESH_SIZE_Y,
  parameter int CUR_X        = 0,
  parameter int CUR_Y        = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  input_port_buffer_if.slave  bus
);

  localparam logic [X_DES_W-1:0] CUR_X_L = X_DES_W'(CUR_X % MESH_SIZE_X);
  localparam logic [Y_DES_W-1:0] CUR_Y_L = Y_DES_W'(CUR_Y % MESH_SIZE_Y);

  flit_Data   front;
  logic       empty, full;
  logic       push, pop, discard, valid, front_is_head;
  port_Dir    xy_dir, route_q, route_d;
  buf_state_e state_q, state_d;
  logic       err_q, err_d;

  flit_fifo #(.DEPTH(BUFFER_DEPTH), .WIDTH(FLIT_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop || discard),
    .wdata_i (bus.flit_In),
    .rdata_o (front),
    .empty_o (empty),
    .full_o  (full)
  );

  assign front_is_head = is_head(front.label);
  assign xy_dir        = xy_route(front.head, CUR_X_L, CUR_Y_L);
  assign push          = bus.valid_In && !full;
  assign valid         = !empty && ((state_q == ROUTED) || front_is_head);
  assign pop           = valid && bus.ready_In;
  // A body/tail with no open packet is never offered; it is dropped here.
  assign discard       = !empty && (state_q == IDLE) && !front_is_head;

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    err_d   = discard;
    if (pop) begin
      case (state_q)
        IDLE: begin
          if (front.label == HEAD) begin
            state_d = ROUTED;
            route_d = xy_dir;
          end
        end
        ROUTED: begin
          // A head inside an open packet closes it and is flagged.
          if (front_is_head) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (front.label == TAIL) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      route_q <= LOCAL;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready_Out = !full;
  assign bus.valid_Out = valid;
  assign bus.flit_Out  = front;
  assign bus.route_Out = (state_q == ROUTED) ? route_q : (valid ? xy_dir : LOCAL);
  assign bus.error_Out = err_q;

endmodule

// File: tb/tb_input_port_buffer.sv
// Self-checking bench for input_port_buffer at CUR=(1,1): directed packets
// with literal expectations plus random traffic against a queue-based model.
module tb_input_port_buffer;
  import input_port_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  input_port_buffer_if bus ();

  input_port_buffer #(
    .BUFFER_DEPTH (4),
    .MESH_SIZE_X  (4),
    .MESH_SIZE_Y  (4),
    .CUR_X        (1),
    .CUR_Y        (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic flit_Data mk(flit_Data_Label l, int x, int y, logic [15:0] p);
    flit_Data f;
    f.label       = l;
    f.head.x_Dest = X_DES_W'(x);
    f.head.y_Dest = Y_DES_W'(y);
    f.payload     = p;
    return f;
  endfunction

  // Reference routing for a router at (1,1), X dimension first.
  function automatic port_Dir ref_route(int xd, int yd);
    if (xd > 1) return EAST;
    if (xd < 1) return WEST;
    if (yd > 1) return NORTH;
    if (yd < 1) return SOUTH;
    return LOCAL;
  endfunction

  function automatic bit ref_is_head(flit_Data_Label l);
    return (l == HEAD) || (l == HEADTAIL);
  endfunction

  // Behavioural model: flit queue, packet-open flag, held route, error pulse.
  flit_Data mq[$];
  bit       m_in_pkt, m_err, m_ready;
  port_Dir  m_route;

  function automatic bit exp_valid();
    if (mq.size() == 0) return 1'b0;
    return m_in_pkt || ref_is_head(mq[0].label);
  endfunction

  function automatic port_Dir exp_route();
    if (m_in_pkt) return m_route;
    return ref_route(int'(mq[0].head.x_Dest), int'(mq[0].head.y_Dest));
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_in_pkt = 1'b0;
        m_err    = 1'b0;
        m_ready  = 1'b0;
        m_route  = LOCAL;
      end else begin
        bit       nonempty, hd, v, push, pop, disc;
        flit_Data f;
        nonempty = (mq.size() != 0);
        f        = nonempty ? mq[0] : '0;
        hd       = ref_is_head(f.label);
        v        = exp_valid();
        push     = bus.valid_In && m_ready;
        pop      = v && bus.ready_In;
        disc     = nonempty && !m_in_pkt && !hd;
        m_err    = disc || (pop && m_in_pkt && hd);
        if (pop) begin
          if (m_in_pkt) m_in_pkt = (f.label == BODY);
          else if (f.label == HEAD) begin
            m_in_pkt = 1'b1;
            m_route  = ref_route(int'(f.head.x_Dest), int'(f.head.y_Dest));
          end
        end
        if (pop || disc) void'(mq.pop_front());
        if (push) mq.push_back(bus.flit_In);
        m_ready = (mq.size() != 4);
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("m_ready", 32'(bus.ready_Out), 32'(m_ready));
        check("m_valid", 32'(bus.valid_Out), 32'(exp_valid()));
        check("m_error", 32'(bus.error_Out), 32'(m_err));
        if (exp_valid()) begin
          check("m_flit",  32'(bus.flit_Out),  32'(mq[0]));
          check("m_route", 32'(bus.route_Out), 32'(exp_route()));
        end
      end
    end
  end

  task automatic step(input bit v, input flit_Data f, input bit r);
    bus.valid_In = v;
    bus.flit_In  = f;
    bus.ready_In = r;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.ready_Out), 32'd0);
    check({tag, "_valid"}, 32'(bus.valid_Out), 32'd0);
    check({tag, "_flit"},  32'(bus.flit_Out),  32'd0);
    check({tag, "_route"}, 32'(bus.route_Out), 32'(LOCAL));
    check({tag, "_error"}, 32'(bus.error_Out), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    flit_Data f;
    rst_n        = 1'b0;
    bus.valid_In = 1'b0;
    bus.flit_In  = '0;
    bus.ready_In = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.ready_Out), 32'd1);

    // Single HEADTAIL to (3,1)
    f = mk(HEADTAIL, 3, 1, 16'hA001);
    step(1'b1, f, 1'b1);
    check("ht_valid", 32'(bus.valid_Out), 32'd1);
    check("ht_route", 32'(bus.route_Out), 32'(EAST));
    check("ht_flit",  32'(bus.flit_Out),  32'(f));
    step(1'b0, '0, 1'b1);
    check("ht_empty", 32'(bus.valid_Out), 32'd0);

    // HEAD (1,0) + 2 BODY + TAIL back-to-back
    step(1'b1, mk(HEAD, 1, 0, 16'hB000), 1'b1);
    check("pkt_head_route", 32'(bus.route_Out), 32'(SOUTH));
    check("pkt_head_flit",  32'(bus.flit_Out),  32'(mk(HEAD, 1, 0, 16'hB000)));
    for (int i = 1; i <= 3; i++) begin
      f = mk((i == 3) ? TAIL : BODY, 0, 0, 16'(16'hB000 + i));
      step(1'b1, f, 1'b1);
      check("pkt_route", 32'(bus.route_Out), 32'(SOUTH));
      check("pkt_flit",  32'(bus.flit_Out),  32'(f));
    end
    step(1'b0, '0, 1'b1);
    check("pkt_drained", 32'(bus.valid_Out), 32'd0);
    step(1'b1, mk(HEADTAIL, 1, 1, 16'hB0FF), 1'b1);
    check("pkt_back_idle", 32'(bus.route_Out), 32'(LOCAL));
    step(1'b0, '0, 1'b1);

    // Fill with ready_In low, then stream through the pointer wrap
    for (int i = 0; i < 4; i++) begin
      step(1'b1, mk((i == 0) ? HEAD : BODY, 1, 2, 16'(16'hC000 + i)), 1'b0);
      check("fill_ready", 32'(bus.ready_Out), (i == 3) ? 32'd0 : 32'd1);
    end
    check("full_route", 32'(bus.route_Out), 32'(NORTH));
    step(1'b1, mk(BODY, 0, 0, 16'hC004), 1'b1);
    check("full_pop_ready", 32'(bus.ready_Out), 32'd1);
    check("full_pop_flit",  32'(bus.flit_Out),  32'(mk(BODY, 1, 2, 16'hC001)));
    step(1'b1, mk(BODY, 0, 0, 16'hC004), 1'b1);
    step(1'b1, mk(TAIL, 0, 0, 16'hC005), 1'b1);
    repeat (5) step(1'b0, '0, 1'b1);
    check("wrap_drained", 32'(bus.valid_Out), 32'd0);

    // Orphan BODY while idle
    step(1'b1, mk(BODY, 0, 0, 16'hD001), 1'b1);
    check("orphan_valid", 32'(bus.valid_Out), 32'd0);
    check("orphan_err0",  32'(bus.error_Out), 32'd0);
    step(1'b1, mk(HEAD, 1, 1, 16'hD002), 1'b1);
    check("orphan_err1",  32'(bus.error_Out), 32'd1);
    check("orphan_next",  32'(bus.route_Out), 32'(LOCAL));
    check("orphan_nextv", 32'(bus.valid_Out), 32'd1);
    step(1'b1, mk(TAIL, 0, 0, 16'hD003), 1'b1);
    check("orphan_err_pulse", 32'(bus.error_Out), 32'd0);
    step(1'b0, '0, 1'b1);

    // Reset in the middle of a packet
    step(1'b1, mk(HEAD, 2, 2, 16'hE000), 1'b1);
    step(1'b1, mk(BODY, 0, 0, 16'hE001), 1'b1);
    bus.valid_In = 1'b0;
    bus.ready_In = 1'b0;
    check("mid_valid", 32'(bus.valid_Out), 32'd1);
    check("mid_route", 32'(bus.route_Out), 32'(EAST));
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1);
    check("rel_ready", 32'(bus.ready_Out), 32'd1);
    step(1'b1, mk(HEADTAIL, 0, 2, 16'hE100), 1'b1);
    check("rel_valid", 32'(bus.valid_Out), 32'd1);
    check("rel_route", 32'(bus.route_Out), 32'(WEST));
    step(1'b0, '0, 1'b1);

    // Random traffic, including malformed packets
    for (int i = 0; i < 3000; i++) begin
      int sel;
      flit_Data_Label l;
      sel = int'($urandom_range(0, 9));
      l   = (sel < 2) ? HEAD : (sel < 6) ? BODY : (sel < 8) ? TAIL : HEADTAIL;
      step($urandom_range(0, 9) < 7,
           mk(l, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 16'($urandom)),
           $urandom_range(0, 9) < 6);
    end
    repeat (10) step(1'b0, '0, 1'b1);
    check("final_empty", 32'(bus.valid_Out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
